// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: sequences core reset, snoops data-memory writes for the riscv-tests tohost
// handshake and reports pass/fail/timeout with the failing test number and a RUN-cycle count.
module riscv_test_monitor #(
    parameter int                XLEN         = 32,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 'h1000,
    parameter int                TIMEOUT      = 5000,
    parameter int                RESET_CYCLES = 1,
    parameter int                CNT_W        = 32,
    parameter int                HALT_ON_DONE = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              core_rst,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN/8-1:0] mem_wstrb,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [XLEN-2:0]   test_num,
    output logic [CNT_W-1:0]  cycle_count
);
    typedef enum logic [1:0] {RESET_HOLD, RUN, DONE} state_t;
    state_t state, state_n;
    logic [31:0] hold_cnt, hold_cnt_n;
    logic core_rst_n, done_n, pass_n, fail_n, timeout_n, hit, expire;
    logic [XLEN-2:0] test_num_n;
    logic [CNT_W-1:0] cycle_count_n;
    assign hit = mem_we && mem_addr == TOHOST_ADDR && &mem_wstrb && mem_wdata[0];
    assign expire = TIMEOUT != 0 && cycle_count == CNT_W'(TIMEOUT - 1);
    always_comb begin
        state_n = state;
        hold_cnt_n = hold_cnt;
        core_rst_n = core_rst;
        done_n = done;
        pass_n = pass;
        fail_n = fail;
        timeout_n = timeout;
        test_num_n = test_num;
        cycle_count_n = cycle_count;
        if (state == RESET_HOLD) begin
            hold_cnt_n = hold_cnt + 32'd1;
            if (hold_cnt == 32'(RESET_CYCLES - 1)) begin
                state_n = RUN;
                core_rst_n = 1'b0;
            end
        end else if (state == RUN) begin
            cycle_count_n = &cycle_count ? cycle_count : cycle_count + CNT_W'(1);
            // a qualifying write on the watchdog's last edge takes precedence
            if (hit || expire) begin
                state_n = DONE;
                done_n = 1'b1;
                core_rst_n = HALT_ON_DONE != 0;
                pass_n = hit && mem_wdata[XLEN-1:1] == '0;
                fail_n = hit && mem_wdata[XLEN-1:1] != '0;
                timeout_n = !hit;
                test_num_n = hit ? mem_wdata[XLEN-1:1] : '0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_HOLD;
            hold_cnt <= '0;
            core_rst <= 1'b1;
            done <= 1'b0;
            pass <= 1'b0;
            fail <= 1'b0;
            timeout <= 1'b0;
            test_num <= '0;
            cycle_count <= '0;
        end else begin
            state <= state_n;
            hold_cnt <= hold_cnt_n;
            core_rst <= core_rst_n;
            done <= done_n;
            pass <= pass_n;
            fail <= fail_n;
            timeout <= timeout_n;
            test_num <= test_num_n;
            cycle_count <= cycle_count_n;
        end
    end
endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb_riscv_test_monitor: three differently parametrised monitors share one stimulus stream and are
// checked every cycle against a cycle-counting reference model plus directed expectations.
module tb_riscv_test_monitor;
    localparam int RC [3] = '{3, 1, 2};
    localparam int TO [3] = '{500, 20, 0};
    localparam int HD [3] = '{1, 1, 0};
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0] strb = '0;
    logic cr [3];
    logic dn [3];
    logic ps [3];
    logic fl [3];
    logic tm [3];
    logic [30:0] tn [3];
    logic [31:0] cc [3];
    int checks = 0;
    int errors = 0;
    int since [3];
    logic md [3];
    logic mp [3];
    logic mf [3];
    logic mt [3];
    longint mtn [3];
    longint mcnt [3];
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        riscv_test_monitor #(
            .TOHOST_ADDR(32'h1000),
            .TIMEOUT(TO[g]),
            .RESET_CYCLES(RC[g]),
            .HALT_ON_DONE(HD[g])
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .core_rst(cr[g]),
            .mem_we(we),
            .mem_addr(addr),
            .mem_wdata(wdata),
            .mem_wstrb(strb),
            .done(dn[g]),
            .pass(ps[g]),
            .fail(fl[g]),
            .timeout(tm[g]),
            .test_num(tn[g]),
            .cycle_count(cc[g])
        );
    end
    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // Model: counts low-reset edges and RUN cycles; a RUN cycle exists once RC edges have passed.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                since[i] = 0;
                md[i] = 0; mp[i] = 0; mf[i] = 0; mt[i] = 0;
                mtn[i] = 0; mcnt[i] = 0;
            end else begin
                if (!md[i] && since[i] >= RC[i]) begin
                    mcnt[i]++;
                    if (we && addr == 32'h1000 && strb == 4'hf && wdata % 2 == 1) begin
                        md[i] = 1;
                        if (wdata == 1) mp[i] = 1;
                        else begin
                            mf[i] = 1;
                            mtn[i] = longint'(wdata / 2);
                        end
                    end else if (TO[i] != 0 && mcnt[i] == TO[i]) begin
                        md[i] = 1;
                        mt[i] = 1;
                    end
                end
                if (since[i] < 1000000) since[i]++;
            end
        end
    endtask
    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d.core_rst", i), 64'(cr[i]), 64'(md[i] ? HD[i] != 0 : since[i] < RC[i]));
            chk($sformatf("u%0d.done", i), 64'(dn[i]), 64'(md[i]));
            chk($sformatf("u%0d.pass", i), 64'(ps[i]), 64'(mp[i]));
            chk($sformatf("u%0d.fail", i), 64'(fl[i]), 64'(mf[i]));
            chk($sformatf("u%0d.timeout", i), 64'(tm[i]), 64'(mt[i]));
            chk($sformatf("u%0d.test_num", i), 64'(tn[i]), 64'(mtn[i]));
            chk($sformatf("u%0d.cycle_count", i), 64'(cc[i]), 64'(mcnt[i]));
        end
    endtask
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask
    task automatic idle(int n);
        we = 0; addr = '0; wdata = '0; strb = '0;
        repeat (n) step();
    endtask
    task automatic do_reset();
        rst = 1; we = 0;
        step();
        rst = 0;
    endtask
    task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] s);
        we = 1; addr = a; wdata = d; strb = s;
        step();
        we = 0;
    endtask
    // Random traffic that can never qualify as a tohost handshake.
    task automatic noise();
        we = 1'($urandom);
        addr = ($urandom % 2 == 1) ? 32'h1000 : 32'h1000 + 32'(4 * $urandom_range(1, 8));
        wdata = $urandom;
        strb = 4'($urandom);
        if (addr == 32'h1000 && strb == 4'hf) wdata[0] = 1'b0;
        step();
    endtask
    task automatic rnd();
        we = ($urandom % 3 == 0);
        addr = ($urandom % 2 == 1) ? 32'h1000 : (($urandom % 2 == 1) ? 32'h1004 : $urandom);
        strb = ($urandom % 2 == 1) ? 4'hf : 4'($urandom);
        wdata = ($urandom % 4 == 0) ? $urandom : $urandom % 32;
        step();
    endtask
    initial begin
        do_reset();
        chk("reset.core_rst", 64'(cr[0]), 1);
        chk("reset.done", 64'(dn[0]), 0);
        chk("reset.cycle_count", 64'(cc[0]), 0);
        idle(1);
        chk("hold1.core_rst", 64'(cr[0]), 1);
        idle(1);
        chk("hold2.core_rst", 64'(cr[0]), 1);
        idle(1);
        chk("hold3.core_rst", 64'(cr[0]), 0);
        chk("hold3.cycle_count", 64'(cc[0]), 0);
        idle(1);
        chk("run1.cycle_count", 64'(cc[0]), 1);
        for (int k = 0; k < 1000 && mcnt[0] < 100; k++) noise();
        wr(32'h1000, 32'h1, 4'hf);
        chk("pass.done", 64'(dn[0]), 1);
        chk("pass.pass", 64'(ps[0]), 1);
        chk("pass.test_num", 64'(tn[0]), 0);
        chk("pass.cycle_count", 64'(cc[0]), 101);
        chk("pass.core_rst_halt", 64'(cr[0]), 1);
        chk("pass.core_rst_nohalt", 64'(cr[2]), 0);
        repeat (50) rnd();
        chk("hold.pass", 64'(ps[0]), 1);
        chk("hold.cycle_count", 64'(cc[0]), 101);
        do_reset();
        idle(5);
        wr(32'h1004, 32'h1, 4'hf);
        chk("filt_addr.done", 64'(dn[0]), 0);
        wr(32'h1000, 32'h1, 4'h1);
        chk("filt_strb.done", 64'(dn[0]), 0);
        wr(32'h1000, 32'h2, 4'hf);
        chk("filt_even.done", 64'(dn[0]), 0);
        wr(32'h1000, 32'h0, 4'hf);
        chk("filt_zero.done", 64'(dn[0]), 0);
        wr(32'h1000, 32'hb, 4'hf);
        chk("fail.fail", 64'(fl[0]), 1);
        chk("fail.pass", 64'(ps[0]), 0);
        chk("fail.test_num", 64'(tn[0]), 5);
        do_reset();
        for (int k = 0; k < 100 && mcnt[1] < 19; k++) noise();
        wr(32'h1000, 32'h1, 4'hf);
        chk("simul.pass", 64'(ps[1]), 1);
        chk("simul.timeout", 64'(tm[1]), 0);
        chk("simul.cycle_count", 64'(cc[1]), 20);
        do_reset();
        idle(25);
        chk("timeout.done", 64'(dn[1]), 1);
        chk("timeout.timeout", 64'(tm[1]), 1);
        chk("timeout.cycle_count", 64'(cc[1]), 20);
        idle(9975);
        chk("nowdog.done", 64'(dn[2]), 0);
        chk("timeout500.cycle_count", 64'(cc[0]), 500);
        do_reset();
        for (int k = 0; k < 100 && mcnt[0] < 7; k++) noise();
        do_reset();
        chk("midrun.core_rst", 64'(cr[0]), 1);
        chk("midrun.cycle_count", 64'(cc[0]), 0);
        idle(30);
        chk("predone.done", 64'(dn[1]), 1);
        do_reset();
        chk("indone.done", 64'(dn[1]), 0);
        chk("indone.timeout", 64'(tm[1]), 0);
        chk("indone.core_rst", 64'(cr[1]), 1);
        idle(10);
        wr(32'h1000, 32'h1, 4'hf);
        chk("fresh.pass0", 64'(ps[0]), 1);
        chk("fresh.pass1", 64'(ps[1]), 1);
        repeat (20) begin
            do_reset();
            for (int k = 0; k < 600 && !(md[0] && md[1] && md[2]); k++) rnd();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
